// File: rtl/imm_ext_stage_pkg.sv
// Shared encodings for the immediate-extension stage: mode selector values and buffer states.
package imm_ext_stage_pkg;

  localparam int EXT_SEL_BUS = 3;

  typedef enum logic [EXT_SEL_BUS-1:0] {
    UNSIGN_EXT = 3'd0,
    SIGN_EXT   = 3'd1,
    LUI        = 3'd2,
    CONST_4    = 3'd3,
    BRANCH_OFS = 3'd4,
    SHAMT      = 3'd5,
    CONST_8    = 3'd6
  } ext_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_stage_if.sv
// ID->stage->EX token bus. slave = the stage itself, master = the surrounding ID/EX logic.
interface imm_ext_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int TAG_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_WIDTH-1:0]  in_imm;
  logic [SEL_WIDTH-1:0]  in_sel;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_bad_sel;

  modport slave (
    input  in_valid, in_imm, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_bad_sel
  );

  modport master (
    output in_valid, in_imm, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_bad_sel
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extender; zero latency, no flow control.
module imm_ext_core
  import imm_ext_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int SEL_WIDTH   = EXT_SEL_BUS,
  parameter int SHAMT_LSB   = 6,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  bad_sel
);

  logic [DATA_WIDTH-1:0] sext;
  assign sext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};

  always_comb begin
    result  = '0;
    bad_sel = 1'b0;
    case (sel)
      SEL_WIDTH'(UNSIGN_EXT): result = DATA_WIDTH'(imm);
      SEL_WIDTH'(SIGN_EXT):   result = sext;
      SEL_WIDTH'(LUI):        result = {imm, {(DATA_WIDTH-IMM_WIDTH){1'b0}}};
      SEL_WIDTH'(CONST_4):    result = DATA_WIDTH'(4);
      // Upper bits of the shifted offset fall off the top of the operand.
      SEL_WIDTH'(BRANCH_OFS): result = sext << 2;
      SEL_WIDTH'(SHAMT):      result = DATA_WIDTH'(imm[SHAMT_LSB +: SHAMT_WIDTH]);
      SEL_WIDTH'(CONST_8):    result = DATA_WIDTH'(8);
      default:                bad_sel = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate extender with 2-entry skid buffer: 1-cycle latency, full throughput.
// in_ready depends only on registered state, so EX stalls never lose a token; flush empties it.
module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int SEL_WIDTH   = EXT_SEL_BUS,
  parameter int SHAMT_LSB   = 6,
  parameter int SHAMT_WIDTH = 5,
  parameter int TAG_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_ext_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  bad_sel;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   accept, drain;

  imm_ext_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .SHAMT_LSB  (SHAMT_LSB),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_core (
    .imm    (bus.in_imm),
    .sel    (bus.in_sel),
    .result (new_entry.imm),
    .bad_sel(new_entry.bad_sel)
  );
  assign new_entry.tag = bus.in_tag;

  assign bus.in_ready    = (state_q != FULL);
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_imm     = main_q.imm;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_bad_sel = main_q.bad_sel;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        main_d  = new_entry;
        state_d = ONE;
      end
      ONE: begin
        if (accept && drain) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: if (drain) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides any same-cycle accept or drain; stale data is left in place.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: mode sweep, back-pressure, streaming, flush and reset.
module tb_imm_ext_stage;

  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  imm_ext_stage_if #(.DATA_WIDTH(32), .IMM_WIDTH(16), .SEL_WIDTH(3), .TAG_WIDTH(8)) bus ();

  imm_ext_stage #(
    .DATA_WIDTH(32), .IMM_WIDTH(16), .SEL_WIDTH(3),
    .SHAMT_LSB(6), .SHAMT_WIDTH(5), .TAG_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [15:0] imm, input logic [2:0] sel,
                       input logic [7:0] tag);
    bus.in_valid = vld;
    bus.in_imm   = imm;
    bus.in_sel   = sel;
    bus.in_tag   = tag;
  endtask

  logic [31:0] exp_mode [8];

  initial begin
    exp_mode[0] = 32'h0000_8004;
    exp_mode[1] = 32'hFFFF_8004;
    exp_mode[2] = 32'h8004_0000;
    exp_mode[3] = 32'h0000_0004;
    exp_mode[4] = 32'hFFFE_0010;
    exp_mode[5] = 32'h0000_0000;
    exp_mode[6] = 32'h0000_0008;
    exp_mode[7] = 32'h0000_0000;

    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    repeat (3) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_bad", 32'(bus.out_bad_sel), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // Mode sweep, pipelined one token per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h8004, 3'(i), 8'(i));
      tick();
      chk($sformatf("mode%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("mode%0d_imm", i), bus.out_imm, exp_mode[i]);
      chk($sformatf("mode%0d_tag", i), 32'(bus.out_tag), 32'(i));
      chk($sformatf("mode%0d_bad", i), 32'(bus.out_bad_sel), (i == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    tick();
    chk("sweep_empty", 32'(bus.out_valid), 32'd0);

    // SHAMT field extraction
    drive(1'b1, 16'h07C0, 3'd5, 8'h55);
    tick();
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    chk("shamt_imm", bus.out_imm, 32'd31);
    chk("shamt_tag", 32'(bus.out_tag), 32'h55);
    chk("shamt_bad", 32'(bus.out_bad_sel), 32'd0);
    tick();

    // Back-pressure: A, B accepted, C held until space frees
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd0, 8'hA0);
    chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 16'h0022, 3'd0, 8'hB0);
    chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_a", 32'(bus.out_tag), 32'hA0);
    drive(1'b1, 16'h0033, 3'd0, 8'hC0);
    tick();
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_tag", 32'(bus.out_tag), 32'hA0);
    chk("bp_hold_imm", bus.out_imm, 32'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out_b", 32'(bus.out_tag), 32'hB0);
    chk("bp_out_b_imm", bus.out_imm, 32'h22);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    chk("bp_out_c", 32'(bus.out_tag), 32'hC0);
    chk("bp_out_c_imm", bus.out_imm, 32'h33);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming: accept and drain every cycle, never FULL
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'(k), 3'd1, 8'(8'h20 + k));
      tick();
      chk($sformatf("stream%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stream%0d_tag", k), 32'(bus.out_tag), 32'(8'h20 + k));
      chk($sformatf("stream%0d_ready", k), 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    tick();
    chk("stream_empty", 32'(bus.out_valid), 32'd0);

    // Flush while FULL with a token offered
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1, 3'd0, 8'h30);
    tick();
    drive(1'b1, 16'h2, 3'd0, 8'h31);
    tick();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h3, 3'd0, 8'h32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 32'(bus.out_valid), 32'd0);

    // Flush in ONE beats a same-cycle accept and drain
    drive(1'b1, 16'h4, 3'd0, 8'h33);
    tick();
    chk("fl1_loaded", 32'(bus.out_tag), 32'h33);
    drive(1'b1, 16'h5, 3'd0, 8'h34);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    chk("fl1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("fl1_dropped", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h6, 3'd0, 8'h40);
    tick();
    drive(1'b1, 16'h7, 3'd0, 8'h41);
    tick();
    chk("rs_full", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_valid", 32'(bus.out_valid), 32'd0);
    chk("rs_imm", bus.out_imm, 32'd0);
    chk("rs_tag", 32'(bus.out_tag), 32'd0);
    chk("rs_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0007, 3'd0, 8'h42);
    tick();
    drive(1'b0, 16'h0, 3'd0, 8'h0);
    chk("rs_first_valid", 32'(bus.out_valid), 32'd1);
    chk("rs_first_tag", 32'(bus.out_tag), 32'h42);
    chk("rs_first_imm", bus.out_imm, 32'h7);
    tick();
    chk("rs_drained", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
